b32to128_stream: RTL and testbench

//   Parametrised width upsizer that packs RATIO words of IN_W bits into one

---
 rtl/b32to128_stream.sv | 100 ++++++++++
 tb/tb_b32to128_stream.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/b32to128_stream.sv
// Width upsizer: packs RATIO input words of IN_W bits into one OUT_W output word.
// The slot counter is internal. in_last flushes a partial word, and unfilled slots read as zero.
module b32to128_stream #(
   parameter int IN_W      = 32,
   parameter int RATIO     = 4,
   parameter int MSB_FIRST = 1,
   localparam int OUT_W    = IN_W * RATIO,
   localparam int CW       = $clog2(RATIO + 1)
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [CW-1:0]    out_count,
   output logic             out_last
);

   // Handshake: a word moves on a side when valid && ready at a rising edge.
   // in_ready depends only on the output register state and out_ready, never on in_valid.

   logic [CW-1:0]    slot_q, slot_d;
   logic [OUT_W-1:0] acc_q, acc_d;
   logic             out_valid_q, out_valid_d;
   logic [OUT_W-1:0] out_data_q, out_data_d;
   logic [CW-1:0]    out_count_q, out_count_d;
   logic             out_last_q, out_last_d;

   logic [OUT_W-1:0] merged;
   logic             accept;
   logic             slot_full;
   int unsigned      slot_idx;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign slot_full = (slot_q == CW'(RATIO - 1));

   // Accumulator with the incoming word already placed in its slot.
   always_comb begin
      slot_idx = (MSB_FIRST != 0) ? (RATIO - 1 - int'(slot_q)) : int'(slot_q);
      merged   = acc_q;
      merged[slot_idx*IN_W +: IN_W] = in_data;
   end

   always_comb begin
      slot_d      = slot_q;
      acc_d       = acc_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_count_d = out_count_q;
      out_last_d  = out_last_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept) begin
         if (slot_full || in_last) begin
            // A fresh emit overrides the drain so back-to-back words keep out_valid high.
            out_valid_d = 1'b1;
            out_data_d  = merged;
            out_count_d = slot_q + CW'(1);
            out_last_d  = in_last;
            slot_d      = '0;
            acc_d       = '0;
         end else begin
            acc_d  = merged;
            slot_d = slot_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         slot_q      <= '0;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_count_q <= '0;
         out_last_q  <= 1'b0;
      end else begin
         slot_q      <= slot_d;
         acc_q       <= acc_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_count_q <= out_count_d;
         out_last_q  <= out_last_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_count = out_count_q;
   assign out_last  = out_last_q;

endmodule

// File: tb/tb_b32to128_stream.sv
// Bench for b32to128_stream: MSB-first and LSB-first instances share one input stream.
// A reference model pushes expected output words to a queue, and these are compared at the output handshake.
module tb_b32to128_stream;

   localparam int IN_W  = 32;
   localparam int RATIO = 4;
   localparam int OUT_W = IN_W * RATIO;
   localparam int CW    = $clog2(RATIO + 1);
   localparam int EW    = OUT_W + CW + 1;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   logic            in_valid = 1'b0;
   logic [IN_W-1:0] in_data  = '0;
   logic            in_last  = 1'b0;
   logic            out_ready = 1'b0;

   logic             m_in_ready, m_out_valid, m_out_last;
   logic [OUT_W-1:0] m_out_data;
   logic [CW-1:0]    m_out_count;
   logic             l_in_ready, l_out_valid, l_out_last;
   logic [OUT_W-1:0] l_out_data;
   logic [CW-1:0]    l_out_count;

   b32to128_stream #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(1)) u_msb (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(m_in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(m_out_valid), .out_ready(out_ready), .out_data(m_out_data),
      .out_count(m_out_count), .out_last(m_out_last)
   );

   b32to128_stream #(.IN_W(IN_W), .RATIO(RATIO), .MSB_FIRST(0)) u_lsb (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(l_in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(l_out_valid), .out_ready(out_ready), .out_data(l_out_data),
      .out_count(l_out_count), .out_last(l_out_last)
   );

   // ---------------- checking ----------------
   int n_total = 0;
   int n_bad   = 0;

   task automatic check_eq(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model + scoreboard ----------------
   logic [EW-1:0]    q_m[$];
   logic [EW-1:0]    q_l[$];
   logic [OUT_W-1:0] acc_m = '0, acc_l = '0;
   int               mdl_slot = 0;
   bit               mdl_ov = 1'b0;
   bit               exp_ready;
   bit               emit;

   function automatic logic [OUT_W-1:0] place(input logic [OUT_W-1:0] acc, input int s,
                                              input logic [IN_W-1:0] w, input bit msb);
      int k;
      k = msb ? (RATIO - 1 - s) : s;
      place = acc;
      place[k*IN_W +: IN_W] = w;
   endfunction

   always @(negedge clock) begin
      exp_ready = !mdl_ov || out_ready;
      check_eq("m_in_ready", EW'(m_in_ready), EW'(exp_ready));
      check_eq("l_in_ready", EW'(l_in_ready), EW'(exp_ready));
      check_eq("m_out_valid", EW'(m_out_valid), EW'(mdl_ov));
      check_eq("l_out_valid", EW'(l_out_valid), EW'(mdl_ov));
      if (mdl_ov) begin
         check_eq("m_qsize", EW'(q_m.size()), EW'(1));
         check_eq("l_qsize", EW'(q_l.size()), EW'(1));
         if (q_m.size() > 0) check_eq("m_out_word", {m_out_data, m_out_count, m_out_last}, q_m[0]);
         if (q_l.size() > 0) check_eq("l_out_word", {l_out_data, l_out_count, l_out_last}, q_l[0]);
      end
      if (reset) begin
         q_m.delete();
         q_l.delete();
         acc_m = '0;
         acc_l = '0;
         mdl_slot = 0;
         mdl_ov = 1'b0;
      end else begin
         if (mdl_ov && out_ready) begin
            if (q_m.size() > 0) void'(q_m.pop_front());
            if (q_l.size() > 0) void'(q_l.pop_front());
         end
         emit = 1'b0;
         if (in_valid && exp_ready) begin
            acc_m = place(acc_m, mdl_slot, in_data, 1'b1);
            acc_l = place(acc_l, mdl_slot, in_data, 1'b0);
            if (mdl_slot == RATIO - 1 || in_last) begin
               q_m.push_back({acc_m, CW'(mdl_slot + 1), in_last});
               q_l.push_back({acc_l, CW'(mdl_slot + 1), in_last});
               acc_m = '0;
               acc_l = '0;
               mdl_slot = 0;
               emit = 1'b1;
            end else begin
               mdl_slot++;
            end
         end
         mdl_ov = emit || (mdl_ov && !out_ready);
      end
   end

   // ---------------- driver tasks ----------------
   int  stalls = 0;
   bit  rand_ready = 1'b0;

   // Called at posedge+#1; returns at posedge+#1 just after the accepting edge.
   task automatic send_word(input logic [IN_W-1:0] d, input logic l);
      int waits;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      waits    = 0;
      forever begin
         @(negedge clock);
         if (m_in_ready) break;
         stalls++;
         waits++;
         if (waits > 200) begin
            check_eq("accept_timeout", EW'(waits), EW'(0));
            break;
         end
         @(posedge clock);
         #1;
         if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic check_zero_outputs(input string tag);
      check_eq({tag, "_m_valid"}, EW'(m_out_valid), EW'(0));
      check_eq({tag, "_m_data"},  EW'(m_out_data),  EW'(0));
      check_eq({tag, "_m_count"}, EW'(m_out_count), EW'(0));
      check_eq({tag, "_m_last"},  EW'(m_out_last),  EW'(0));
      check_eq({tag, "_l_data"},  EW'(l_out_data),  EW'(0));
      check_eq({tag, "_l_count"}, EW'(l_out_count), EW'(0));
   endtask

   logic [OUT_W-1:0] held;

   // ---------------- main sequence ----------------
   initial begin
      idle(3);
      reset = 1'b0;
      @(negedge clock);
      check_zero_outputs("reset");
      @(posedge clock);
      #1;

      // full word, sink always ready
      out_ready = 1'b1;
      send_word(32'h11111111, 1'b0);
      send_word(32'h22222222, 1'b0);
      send_word(32'h33333333, 1'b0);
      send_word(32'h44444444, 1'b0);
      @(negedge clock);
      check_eq("t1_m_valid", EW'(m_out_valid), EW'(1));
      check_eq("t1_m_data",  EW'(m_out_data), EW'(128'h11111111_22222222_33333333_44444444));
      check_eq("t2_l_data",  EW'(l_out_data), EW'(128'h44444444_33333333_22222222_11111111));
      check_eq("t1_count",   EW'(m_out_count), EW'(4));
      check_eq("t1_last",    EW'(m_out_last), EW'(0));
      @(posedge clock);
      #1;

      // partial packet flushed by in_last
      send_word(32'hAAAAAAAA, 1'b0);
      send_word(32'hBBBBBBBB, 1'b1);
      @(negedge clock);
      check_eq("t3_m_data",  EW'(m_out_data), EW'(128'hAAAAAAAA_BBBBBBBB_00000000_00000000));
      check_eq("t3_l_data",  EW'(l_out_data), EW'(128'h00000000_00000000_BBBBBBBB_AAAAAAAA));
      check_eq("t3_count",   EW'(m_out_count), EW'(2));
      check_eq("t3_last",    EW'(m_out_last), EW'(1));
      @(posedge clock);
      #1;
      send_word(32'hC0C0C0C0, 1'b0);
      send_word(32'hC1C1C1C1, 1'b1);
      @(negedge clock);
      check_eq("t3_restart", EW'(m_out_data), EW'(128'hC0C0C0C0_C1C1C1C1_00000000_00000000));
      @(posedge clock);
      #1;

      // output held with a word pending, then drained back-to-back
      idle(2);
      out_ready = 1'b0;
      send_word(32'h01010101, 1'b0);
      send_word(32'h02020202, 1'b0);
      send_word(32'h03030303, 1'b0);
      send_word(32'h04040404, 1'b0);
      held = 128'h01010101_02020202_03030303_04040404;
      in_valid = 1'b1;
      in_data  = 32'h05050505;
      repeat (10) begin
         @(negedge clock);
         check_eq("t4_in_ready", EW'(m_in_ready), EW'(0));
         check_eq("t4_hold", EW'(m_out_data), EW'(held));
      end
      @(posedge clock);
      #1;
      out_ready = 1'b1;
      send_word(32'h05050505, 1'b0);
      send_word(32'h06060606, 1'b0);
      send_word(32'h07070707, 1'b0);
      send_word(32'h08080808, 1'b0);
      @(negedge clock);
      check_eq("t4_new_word", EW'(m_out_data), EW'(128'h05050505_06060606_07070707_08080808));
      @(posedge clock);
      #1;

      // 8 words streamed, no stalls
      stalls = 0;
      for (int i = 0; i < 8; i++) send_word(IN_W'(32'hD0000000 + i), 1'b0);
      check_eq("t5_stalls", EW'(stalls), EW'(0));
      // single-word packets: each emit replaces the previous one with out_valid kept high
      for (int i = 0; i < 4; i++) send_word(IN_W'(32'hE0000000 + i), 1'b1);
      check_eq("t5_stalls_last", EW'(stalls), EW'(0));

      // reset in the middle of a packet
      send_word(32'hDEAD0001, 1'b0);
      send_word(32'hDEAD0002, 1'b0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(negedge clock);
      check_zero_outputs("t6_reset");
      @(posedge clock);
      #1;
      send_word(32'h5A000001, 1'b0);
      send_word(32'h5A000002, 1'b0);
      send_word(32'h5A000003, 1'b0);
      send_word(32'h5A000004, 1'b0);
      @(negedge clock);
      check_eq("t6_clean", EW'(m_out_data), EW'(128'h5A000001_5A000002_5A000003_5A000004));
      @(posedge clock);
      #1;

      // random traffic with backpressure
      rand_ready = 1'b1;
      for (int i = 0; i < 80; i++) begin
         out_ready = 1'($urandom_range(0, 1));
         send_word(IN_W'($urandom), ($urandom_range(0, 4) == 0));
         if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      end
      rand_ready = 1'b0;

      out_ready = 1'b1;
      idle(4);
      @(negedge clock);
      check_eq("drain_m", EW'(q_m.size()), EW'(0));
      check_eq("drain_l", EW'(q_l.size()), EW'(0));

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout got=%0t exp=finish", $time);
      $fatal(1, "timeout");
   end

endmodule
